// File: rtl/decoder_pkg.sv
// Shared types and helpers for the strobed binary-to-one-hot decoder.
package decoder_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE   = 1'b0;
  localparam state_t STROBE = 1'b1;

  localparam int MAX_IN_W = 5;

  function automatic logic [31:0] onehot(input logic [MAX_IN_W-1:0] code);
    return 32'd1 << code;
  endfunction

endpackage

// File: rtl/decoder_strobe_onehot_dec.sv
// Combinational IN_W-to-2**IN_W decoder with enable; all-zero when disabled.
import decoder_pkg::*;

module onehot_dec #(
  parameter int IN_W = 2
) (
  input  logic                 en,
  input  logic [IN_W-1:0]      code,
  output logic [2**IN_W-1:0]   dec
);

  localparam int OUT_W = 2**IN_W;

  assign dec = en ? OUT_W'(onehot(MAX_IN_W'(code))) : '0;

endmodule

// File: rtl/decoder_strobe.sv
// Accepts a code over valid/ready and drives one registered one-hot line
// for PULSE_LEN cycles, with an idle cycle between consecutive strobes.
import decoder_pkg::*;

module decoder_strobe #(
  parameter int IN_W      = 2,
  parameter int PULSE_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_code,
  output logic [2**IN_W-1:0]  out_onehot,
  output logic                out_active,
  output logic                done,
  output logic [IN_W-1:0]     last_code
);

  localparam int OUT_W = 2**IN_W;
  localparam int CNT_W = $clog2(PULSE_LEN + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [OUT_W-1:0]   dec;
  logic               fire;

  assign in_ready = en && (state == IDLE);
  assign fire     = in_valid && in_ready;

  onehot_dec #(.IN_W(IN_W)) u_dec (
    .en   (fire),
    .code (in_code),
    .dec  (dec)
  );

  // NOTE: every control and output flop is async-cleared so an asserted
  // rst_n drops the strobe immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out_onehot <= '0;
      out_active <= 1'b0;
      done       <= 1'b0;
      last_code  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of state and cnt regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            state      <= STROBE;
            cnt        <= CNT_W'(PULSE_LEN - 1);
            out_onehot <= dec;
            out_active <= 1'b1;
            last_code  <= in_code;
            done       <= (PULSE_LEN == 1);
          end
        end
        STROBE: begin
          if (!en || cnt == '0) begin
            state      <= IDLE;
            out_onehot <= '0;
            out_active <= 1'b0;
          end else begin
            cnt  <= cnt - CNT_W'(1);
            // done is registered, so raise it one edge ahead of the last cycle
            done <= (cnt == CNT_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_strobe.sv
// Self-checking bench: a per-cycle behavioural model plus directed literal checks.
module tb_decoder_strobe;

  localparam int PL_A = 4;
  localparam int PL_B = 1;

  logic clk, rst_n;
  logic en, in_valid, in_ready;
  logic [1:0] in_code, last_code;
  logic [3:0] out_onehot;
  logic out_active, done;

  logic en_b, valid_b, ready_b;
  logic [2:0] code_b, last_b;
  logic [7:0] onehot_b;
  logic active_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  decoder_strobe #(.IN_W(2), .PULSE_LEN(PL_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_onehot(out_onehot), .out_active(out_active),
    .done(done), .last_code(last_code)
  );

  decoder_strobe #(.IN_W(3), .PULSE_LEN(PL_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_code(code_b), .out_onehot(onehot_b), .out_active(active_b),
    .done(done_b), .last_code(last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a strobe is "busy" for exactly PL cycles after an accepted transfer.
  int ma_busy, ma_code, ma_rem, ma_last;
  int mb_busy, mb_code, mb_rem, mb_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_busy <= 0; ma_code <= 0; ma_rem <= 0; ma_last <= 0;
    end else if (ma_busy != 0) begin
      if (!en || ma_rem == 1) ma_busy <= 0;
      ma_rem <= ma_rem - 1;
    end else if (en && in_valid) begin
      check("a_code_known", 32'($isunknown(in_code)), 32'd0);
      ma_busy <= 1; ma_code <= int'(in_code); ma_rem <= PL_A; ma_last <= int'(in_code);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_busy <= 0; mb_code <= 0; mb_rem <= 0; mb_last <= 0;
    end else if (mb_busy != 0) begin
      if (!en_b || mb_rem == 1) mb_busy <= 0;
      mb_rem <= mb_rem - 1;
    end else if (en_b && valid_b) begin
      check("b_code_known", 32'($isunknown(code_b)), 32'd0);
      mb_busy <= 1; mb_code <= int'(code_b); mb_rem <= PL_B; mb_last <= int'(code_b);
    end
  end

  always @(negedge clk) begin
    check("a_onehot", 32'(out_onehot), (ma_busy != 0) ? (32'd1 << ma_code) : 32'd0);
    check("a_active", 32'(out_active), 32'(ma_busy != 0));
    check("a_done",   32'(done),       32'(ma_busy != 0 && ma_rem == 1));
    check("a_ready",  32'(in_ready),   32'(en && ma_busy == 0));
    check("a_last",   32'(last_code),  32'(ma_last));
    check("b_onehot", 32'(onehot_b),   (mb_busy != 0) ? (32'd1 << mb_code) : 32'd0);
    check("b_done",   32'(done_b),     32'(mb_busy != 0 && mb_rem == 1));
    check("b_ready",  32'(ready_b),    32'(en_b && mb_busy == 0));
    check("b_last",   32'(last_b),     32'(mb_last));
  end

  logic       log_on = 1'b0;
  logic [3:0] hist[$];
  always @(negedge clk) if (log_on) hist.push_back(out_onehot);

  // Present a code on dut_a and hold in_valid until an edge accepts it.
  task automatic send_a(input int c);
    logic r;
    bit fired;
    in_code  = 2'(c);
    in_valid = 1'b1;
    fired    = 1'b0;
    for (int k = 0; k < 20 && !fired; k++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      fired = r;
    end
    if (!fired) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int i0;
    logic [3:0] exp_seq[$];
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_code = '0;
    en_b = 1'b0; valid_b = 1'b0; code_b = '0;

    #12;
    check("rst_onehot", 32'(out_onehot), 32'd0);
    check("rst_last",   32'(last_code),  32'd0);
    check("rst_done",   32'(done),       32'd0);
    check("rst_ready_en0", 32'(in_ready), 32'd0);
    en = 1'b1; en_b = 1'b1;
    #1;
    check("rst_ready_en1", 32'(in_ready), 32'd1);
    #4 rst_n = 1'b1;

    // Single transfer of code 2
    @(posedge clk); #1;
    send_a(2);
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("t1_onehot", 32'(out_onehot), (i <= 4) ? 32'h4 : 32'h0);
      check("t1_done",   32'(done),       32'(i == 4));
      check("t1_ready",  32'(in_ready),   32'(i == 5));
    end

    // Back-to-back sweep of every code
    @(posedge clk); #1;
    log_on = 1'b1;
    for (int c = 0; c < 4; c++) send_a(c);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    log_on = 1'b0;
    check("sweep_last", 32'(last_code), 32'd3);
    for (int c = 0; c < 4; c++) begin
      repeat (4) exp_seq.push_back(4'(1 << c));
      if (c < 3) exp_seq.push_back(4'h0);
    end
    i0 = -1;
    for (int i = 0; i < hist.size(); i++) if (i0 < 0 && hist[i] != 4'h0) i0 = i;
    if (i0 < 0 || i0 + exp_seq.size() > hist.size()) begin
      check("sweep_len", 32'(hist.size()), 32'(exp_seq.size()));
    end else begin
      for (int i = 0; i < exp_seq.size(); i++)
        check("sweep_seq", 32'(hist[i0 + i]), 32'(exp_seq[i]));
    end

    // Abort: en drops during the second strobe cycle
    send_a(1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    check("abort_cyc2", 32'(out_onehot), 32'h2);
    @(negedge clk);
    check("abort_onehot", 32'(out_onehot), 32'h0);
    check("abort_done",   32'(done),       32'd0);
    check("abort_last",   32'(last_code),  32'd1);
    repeat (3) begin
      @(negedge clk);
      check("abort_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk);
    check("abort_ready_back", 32'(in_ready), 32'd1);

    // en low in IDLE blocks a pending transfer
    @(posedge clk); #1;
    en = 1'b0; in_valid = 1'b1; in_code = 2'd3;
    repeat (3) begin
      @(negedge clk);
      check("en0_onehot", 32'(out_onehot), 32'd0);
      check("en0_ready",  32'(in_ready),   32'd0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("en1_onehot", 32'(out_onehot), 32'h8);
    repeat (6) @(posedge clk);
    #1;

    // PULSE_LEN=1, IN_W=3, code 5
    valid_b = 1'b1; code_b = 3'd5;
    @(posedge clk); #1;
    valid_b = 1'b0;
    @(negedge clk);
    check("pl1_onehot", 32'(onehot_b), 32'h20);
    check("pl1_done",   32'(done_b),   32'd1);
    check("pl1_active", 32'(active_b), 32'd1);
    @(negedge clk);
    check("pl1_after",  32'(onehot_b), 32'd0);
    check("pl1_done0",  32'(done_b),   32'd0);
    check("pl1_ready",  32'(ready_b),  32'd1);

    // Asynchronous reset in the middle of a strobe
    @(posedge clk); #1;
    send_a(3);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_onehot", 32'(out_onehot), 32'h8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_onehot", 32'(out_onehot), 32'd0);
    check("mid_rst_active", 32'(out_active), 32'd0);
    check("mid_rst_done",   32'(done),       32'd0);
    check("mid_rst_last",   32'(last_code),  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready",  32'(in_ready),   32'd1);
    check("post_rst_onehot", 32'(out_onehot), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_strobe.md
Name: decoder_strobe

Overview:
- Clocked binary-to-one-hot decoder; the receive-side counterpart of the team's 4-to-2 encoder.
- Accepts a code through a valid/ready handshake, then drives exactly one output line high for PULSE_LEN cycles.
- Guarantees non-overlapping strobes, with at least one all-zero cycle between them.
- Used to fan a compact select code out to per-line enables: chip selects, LED/segment lines, mux selects.

Parameters:
- IN_W, 2, code width; the output is 2**IN_W lines wide (legal range 1..5).
- PULSE_LEN, 4, strobe length in clock cycles (legal range 1..255).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- en  input  1  block enable; low blocks acceptance and aborts an active strobe.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  IN_W  binary code to decode.
- out_onehot  output  2**IN_W  registered one-hot strobe; bit k is high iff the active code == k.
- out_active  output  1  OR of out_onehot.
- done  output  1  one-cycle pulse on the final strobe cycle of a completed (non-aborted) strobe.
- last_code  output  IN_W  code of the most recently accepted transfer.

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_onehot=0, out_active=0, done=0, last_code=0, counter=0. in_ready then evaluates to en.
- States:
  - IDLE: outputs zero.
  - STROBE: out_onehot = 1 << code_reg.
- in_ready = en && (state==IDLE). It is combinational from state and en only, with no dependence on in_valid.
- Transfer: occurs at rising edge T when in_valid && in_ready.
  - Captures code_reg and last_code.
  - State goes to STROBE and counter is loaded with PULSE_LEN-1.
- Latency: out_onehot is high in cycles T+1 .. T+PULSE_LEN, then IDLE in cycle T+PULSE_LEN+1 with outputs zero.
- Back-to-back transfers are therefore spaced at least PULSE_LEN+1 cycles apart.
- STROBE operation:
  - Each cycle with counter>0: decrement.
  - Counter==0: done=1 this cycle; next state IDLE.
  - PULSE_LEN=1: single strobe cycle, with done high in that same cycle.
- Abort: en low in any STROBE cycle (sampled at the edge).
  - Next cycle: IDLE, outputs zero, done never asserted.
  - last_code keeps the aborted code.
- en low in IDLE: in_ready=0, in_valid is ignored, and state is unchanged.
- in_valid while busy: ignored, with no queuing. The producer must hold in_valid until in_ready.
- Output glitch rule: out_onehot, out_active and done are driven straight from flops, so there is never more than one bit high.
- rst_n asserted mid-strobe: outputs clear immediately (asynchronously); no done pulse.
- in_code must not be X when the transfer fires. The bench flags X on in_code during a transfer as an error.

Decomposition:
- Shared package decoder_pkg:
  - state enum {IDLE, STROBE};
  - function onehot(code) returning 1<<code;
  - constant CNT_W = $clog2(PULSE_LEN+1), computed locally since it depends on a parameter.
- One natural sub-module: onehot_dec, a pure combinational IN_W-to-2**IN_W decoder with an enable input.
  - It is instantiated once.
  - Its output is registered in decoder_strobe.
  - It is reusable as the direct inverse-check model against the encoder.

Test Plan:
- Reset, then en=1, in_code=2'b10 with in_valid for 1 cycle at T -> in_ready=0 from T+1; out_onehot=4'b0100 for cycles T+1..T+4; done=1 only at T+4; T+5 out_onehot=0, in_ready=1.
- Sweep all codes 0..3 back-to-back with in_valid held high -> strobes 0001, 0010, 0100, 1000, each 4 cycles long, each separated by exactly one zero cycle; last_code=3 at end.
- Abort: accept code 1, drop en at the 2nd strobe cycle -> next cycle out_onehot=0, done never pulses, last_code=1, in_ready=0 until en=1.
- en=0 in IDLE with in_valid=1, code 3 -> no transfer, out_onehot stays 0; raise en -> transfer the next edge, 1000 strobe.
- PULSE_LEN=1, IN_W=3, code 5 -> single cycle out_onehot=8'b0010_0000 with done=1 in the same cycle.
- Assert rst_n=0 mid-strobe (code 3) -> out_onehot=0 before the next clock edge, last_code=0; after release, in_ready=1 with en high.
